heartbeat_adc_comp: RTL and testbench



---
 rtl/heartbeat_adc_comp_if.sv | 22 ++
 rtl/heartbeat_adc_comp.sv | 147 ++++++++++++++
 tb/tb_heartbeat_adc_comp.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/heartbeat_adc_comp_if.sv
// Signal bundle between the SWIPT receive front end and its surroundings.
// The design side uses the slave modport; the driver side uses master.
interface heartbeat_adc_comp_if;
   logic        swiptONHeartbeat;
   logic [11:0] ADC;
   logic        swipt;
   logic        ADC_comp;

   modport master (
      output swiptONHeartbeat,
      output ADC,
      input  swipt,
      input  ADC_comp
   );

   modport slave (
      input  swiptONHeartbeat,
      input  ADC,
      output swipt,
      output ADC_comp
   );
endinterface

// File: rtl/heartbeat_adc_comp.sv
// SWIPT receive front end: heartbeat liveness monitor plus hysteresis ADC slicer.
// Optional glitch filter on the sliced output is enabled by defining ADC_COMP_FILTER_EN.
module heartbeat_adc_comp #(
   parameter int          HB_TIMEOUT   = 256,
   parameter int          HB_MIN_EDGES = 4,
   parameter logic [11:0] ADC_THRESH   = 12'h800,
   parameter logic [11:0] ADC_HYST     = 12'h020
) (
   input  logic                 clk,
   input  logic                 nrst,
   heartbeat_adc_comp_if.slave  bus
);

   localparam int GAP_W = $clog2(HB_TIMEOUT + 1);
   localparam int CNT_W = $clog2(HB_MIN_EDGES + 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(HB_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HB_MIN_EDGES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Thresholds are clamped to the 12-bit sample range.
   localparam logic [12:0] SUM_HI = {1'b0, ADC_THRESH} + {1'b0, ADC_HYST};
   localparam logic [12:0] UPPER  = (SUM_HI > 13'd4095) ? 13'd4095 : SUM_HI;
   localparam logic [12:0] LOWER  = (ADC_THRESH >= ADC_HYST)
                                    ? ({1'b0, ADC_THRESH} - {1'b0, ADC_HYST}) : 13'd0;

   typedef enum logic [1:0] {
      DEAD,
      ARMING,
      ALIVE
   } state_t;

   logic             hb_s1;
   logic             hb_s2;
   logic             hb_s3;
   logic             hb_edge;
   state_t           state;
   logic [GAP_W-1:0] gap;
   logic [CNT_W-1:0] edge_cnt;
   logic             swipt_q;
   logic [11:0]      adc_q;
   logic             raw;
   logic             raw_next;

   assign hb_edge = hb_s2 ^ hb_s3;

   always_ff @(posedge clk) begin
      if (nrst) begin
         hb_s1 <= 1'b0;
         hb_s2 <= 1'b0;
         hb_s3 <= 1'b0;
      end else begin
         hb_s1 <= bus.swiptONHeartbeat;
         hb_s2 <= hb_s1;
         hb_s3 <= hb_s2;
      end
   end

   // An edge always beats a coincident timeout, so the edge branches come first.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state    <= DEAD;
         gap      <= '0;
         edge_cnt <= '0;
         swipt_q  <= 1'b0;
      end else begin
         swipt_q <= (state == ALIVE);
         if (hb_edge || state == DEAD)
            gap <= '0;
         else if (gap != GAP_MAX)
            gap <= gap + 1'b1;

         case (state)
            DEAD: begin
               edge_cnt <= '0;
               if (hb_edge) begin
                  state    <= ARMING;
                  edge_cnt <= CNT_ONE;
               end
            end
            ARMING: begin
               if (hb_edge) begin
                  edge_cnt <= edge_cnt + CNT_ONE;
                  if (edge_cnt + CNT_ONE == CNT_MAX)
                     state <= ALIVE;
               end else if (gap == GAP_MAX) begin
                  state    <= DEAD;
                  edge_cnt <= '0;
               end
            end
            ALIVE: begin
               if (!hb_edge && gap == GAP_MAX) begin
                  state    <= DEAD;
                  edge_cnt <= '0;
               end
            end
            default: begin
               state    <= DEAD;
               edge_cnt <= '0;
            end
         endcase
      end
   end

   always_comb begin
      raw_next = raw;
      if (!swipt_q)
         raw_next = 1'b0;
      else if (!raw && ({1'b0, adc_q} >= UPPER))
         raw_next = 1'b1;
      else if (raw && ({1'b0, adc_q} < LOWER))
         raw_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         adc_q <= '0;
         raw   <= 1'b0;
      end else begin
         adc_q <= bus.ADC;
         raw   <= raw_next;
      end
   end

   assign bus.swipt = swipt_q;

`ifdef ADC_COMP_FILTER_EN
   logic raw_d1;
   logic comp_q;

   // The vote takes the decision entering raw plus the raw/raw_d1 history,
   // so a lone one-cycle decision never wins and only one cycle is added.
   always_ff @(posedge clk) begin
      if (nrst || !swipt_q) begin
         raw_d1 <= 1'b0;
         comp_q <= 1'b0;
      end else begin
         raw_d1 <= raw;
         comp_q <= (raw_next & raw) | (raw_next & raw_d1) | (raw & raw_d1);
      end
   end

   assign bus.ADC_comp = comp_q;
`else
   assign bus.ADC_comp = raw;
`endif

endmodule

// File: tb/tb_heartbeat_adc_comp.sv
// Directed self-checking bench for heartbeat_adc_comp (default or ADC_COMP_FILTER_EN build).
module tb_heartbeat_adc_comp;

`ifdef ADC_COMP_FILTER_EN
   localparam int FILT = 1;
`else
   localparam int FILT = 0;
`endif

   logic clk;
   logic nrst;
   int   checks;
   int   errors;
   int   cyc;
   int   det_cyc;
   logic hb_level;
   logic [11:0] adc_level;

   heartbeat_adc_comp_if bus ();

   heartbeat_adc_comp dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic hb, input logic [11:0] adc);
      hb_level             = hb;
      adc_level            = adc;
      bus.swiptONHeartbeat = hb;
      bus.ADC              = adc;
   endtask

   task automatic runCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Four heartbeat toggles 90 cycles apart; swipt must rise exactly 4 cycles after the last.
   task automatic acquire(input string tag);
      for (int e = 1; e <= 3; e++) begin
         applyStimulus(~hb_level, adc_level);
         runCycles(89);
         checkOutput({tag, "_pre_alive"}, 32'(bus.swipt), 32'd0);
         runCycles(1);
      end
      applyStimulus(~hb_level, adc_level);
      runCycles(3);
      checkOutput({tag, "_edge4_plus3"}, 32'(bus.swipt), 32'd0);
      det_cyc = cyc;
      runCycles(1);
      checkOutput({tag, "_edge4_plus4"}, 32'(bus.swipt), 32'd1);
   endtask

   initial begin
      logic [11:0] ramp [4];
      logic        exp_bit;
      ramp[0] = 12'h000;
      ramp[1] = 12'h400;
      ramp[2] = 12'h7FF;
      ramp[3] = 12'h81F;
      checks = 0;
      errors = 0;
      cyc    = 0;
      nrst   = 1'b1;
      applyStimulus(1'b0, 12'h000);

      runCycles(5);
      checkOutput("reset_swipt", 32'(bus.swipt), 32'd0);
      checkOutput("reset_comp", 32'(bus.ADC_comp), 32'd0);
      nrst = 1'b0;
      runCycles(3);

      acquire("acq");

      // Below the upper threshold nothing sets.
      foreach (ramp[i]) begin
         applyStimulus(hb_level, ramp[i]);
         runCycles(4);
         checkOutput($sformatf("hyst_below_%0h", ramp[i]), 32'(bus.ADC_comp), 32'd0);
      end
      applyStimulus(hb_level, 12'h820);
      runCycles(1 + FILT);
      checkOutput("hyst_820_early", 32'(bus.ADC_comp), 32'd0);
      runCycles(1);
      checkOutput("hyst_820_set", 32'(bus.ADC_comp), 32'd1);
      runCycles(3);
      applyStimulus(hb_level, 12'h7E0);
      runCycles(4);
      checkOutput("hyst_7e0_hold", 32'(bus.ADC_comp), 32'd1);
      applyStimulus(hb_level, 12'h7DF);
      runCycles(1 + FILT);
      checkOutput("hyst_7df_early", 32'(bus.ADC_comp), 32'd1);
      runCycles(1);
      checkOutput("hyst_7df_clear", 32'(bus.ADC_comp), 32'd0);
      runCycles(3);

      // Short full-scale pulses from a low level.
      for (int len = 1; len <= 2; len++) begin
         applyStimulus(hb_level, 12'h000);
         runCycles(3);
         applyStimulus(hb_level, 12'hFFF);
         for (int k = 1; k <= 6; k++) begin
            runCycles(1);
            if (FILT == 1)
               exp_bit = (len == 2) && (k == 3 || k == 4);
            else
               exp_bit = (k >= 2) && (k <= len + 1);
            checkOutput($sformatf("glitch_len%0d_k%0d", len, k), 32'(bus.ADC_comp), 32'(exp_bit));
            if (k == len)
               applyStimulus(hb_level, 12'h000);
         end
      end

      // Stop the heartbeat with the comparator high.
      applyStimulus(hb_level, 12'hFFF);
      while (cyc < det_cyc + 256) runCycles(1);
      checkOutput("loss_swipt_still_high", 32'(bus.swipt), 32'd1);
      checkOutput("loss_comp_high", 32'(bus.ADC_comp), 32'd1);
      runCycles(2);
      checkOutput("loss_swipt_low", 32'(bus.swipt), 32'd0);
      runCycles(1);
      checkOutput("loss_comp_low", 32'(bus.ADC_comp), 32'd0);
      runCycles(20);
      checkOutput("gating_comp_dead", 32'(bus.ADC_comp), 32'd0);

      // Heartbeat too slow to ever arm fully.
      for (int e = 0; e < 3; e++) begin
         applyStimulus(~hb_level, 12'hFFF);
         for (int j = 1; j <= 6; j++) begin
            runCycles(50);
            checkOutput($sformatf("slow_e%0d_swipt_%0d", e, j), 32'(bus.swipt), 32'd0);
            checkOutput($sformatf("slow_e%0d_comp_%0d", e, j), 32'(bus.ADC_comp), 32'd0);
         end
      end

      // Re-acquire with a high sample, then reset mid-operation.
      acquire("reacq");
      runCycles(3);
      checkOutput("reacq_comp_high", 32'(bus.ADC_comp), 32'd1);
      nrst = 1'b1;
      runCycles(1);
      checkOutput("midreset_swipt", 32'(bus.swipt), 32'd0);
      checkOutput("midreset_comp", 32'(bus.ADC_comp), 32'd0);
      nrst = 1'b0;
      runCycles(5);
      checkOutput("postreset_swipt", 32'(bus.swipt), 32'd0);
      checkOutput("postreset_comp", 32'(bus.ADC_comp), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
